// File: rtl/mmio_io_responder.sv
// Memory-mapped I/O responder: LED, 4-digit seven-segment, debounced switches and a free-running
// cycle timer behind a 16-byte window with byte-lane writes and one-cycle registered reads.
module mmio_io_responder #(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_4000,
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
    parameter logic [16:0] REFRESH_CYCLES  = 17'd100000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] address_i,
    input  logic [31:0] write_data_i,
    input  logic [3:0]  write_enable_i,
    input  logic        read_enable_i,
    output logic [31:0] read_data_o,
    output logic        read_valid_o,
    input  logic [3:0]  sw_i,
    output logic [3:0]  led_o,
    output logic [6:0]  seg_o,
    output logic [3:0]  an_o
);

    logic        hit;
    logic [1:0]  offset;
    logic        unused_addr;
    logic [15:0] seg_reg_q;
    logic [31:0] timer_q, timer_d;
    logic [31:0] rd_mux;
    logic [3:0]  sync1_q, sync2_q, stable_q;
    logic [19:0] cnt_q [4];
    logic [16:0] rcnt_q;
    logic [1:0]  idx_q, idx_next;
    logic [3:0]  next_digit;

    assign hit         = (address_i[31:4] == BASE_ADDR[31:4]);
    assign offset      = address_i[3:2];
    assign unused_addr = ^address_i[1:0];

    function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
        case (d)
            4'h0:    hex_to_seg = 7'b1000000;
            4'h1:    hex_to_seg = 7'b1111001;
            4'h2:    hex_to_seg = 7'b0100100;
            4'h3:    hex_to_seg = 7'b0110000;
            4'h4:    hex_to_seg = 7'b0011001;
            4'h5:    hex_to_seg = 7'b0010010;
            4'h6:    hex_to_seg = 7'b0000010;
            4'h7:    hex_to_seg = 7'b1111000;
            4'h8:    hex_to_seg = 7'b0000000;
            4'h9:    hex_to_seg = 7'b0010000;
            4'hA:    hex_to_seg = 7'b0001000;
            4'hB:    hex_to_seg = 7'b0000011;
            4'hC:    hex_to_seg = 7'b1000110;
            4'hD:    hex_to_seg = 7'b0100001;
            4'hE:    hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    // Read mux sees register state before this edge's writes take effect.
    always_comb begin
        rd_mux = 32'h0;
        if (hit) begin
            case (offset)
                2'd0:    rd_mux = {28'h0, led_o};
                2'd1:    rd_mux = {16'h0, seg_reg_q};
                2'd2:    rd_mux = {28'h0, stable_q};
                default: rd_mux = timer_q;
            endcase
        end
    end

    // A timer write freezes unstrobed bytes for that cycle instead of incrementing them.
    always_comb begin
        if (hit && offset == 2'd3 && write_enable_i != 4'b0000) begin
            timer_d = timer_q;
            for (int b = 0; b < 4; b++) begin
                if (write_enable_i[b]) begin
                    timer_d[8*b +: 8] = write_data_i[8*b +: 8];
                end
            end
        end else begin
            timer_d = timer_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            led_o        <= 4'h0;
            seg_reg_q    <= 16'h0;
            timer_q      <= 32'h0;
            read_data_o  <= 32'h0;
            read_valid_o <= 1'b0;
        end else begin
            timer_q      <= timer_d;
            read_valid_o <= read_enable_i;
            if (read_enable_i) begin
                read_data_o <= rd_mux;
            end
            if (hit && offset == 2'd0 && write_enable_i[0]) begin
                led_o <= write_data_i[3:0];
            end
            if (hit && offset == 2'd1) begin
                if (write_enable_i[0]) seg_reg_q[7:0]  <= write_data_i[7:0];
                if (write_enable_i[1]) seg_reg_q[15:8] <= write_data_i[15:8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q  <= 4'h0;
            sync2_q  <= 4'h0;
            stable_q <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= 20'd0;
            end
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    cnt_q[i] <= 20'd0;
                end else if (cnt_q[i] == DEBOUNCE_CYCLES - 20'd1) begin
                    stable_q[i] <= sync2_q[i];
                    cnt_q[i]    <= 20'd0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 20'd1;
                end
            end
        end
    end

    assign idx_next   = idx_q + 2'd1;
    assign next_digit = seg_reg_q[{idx_next, 2'b00} +: 4];

    // Anode and segment pattern are only reloaded on a digit change, so they always agree.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rcnt_q <= 17'd0;
            idx_q  <= 2'd0;
            an_o   <= 4'b1110;
            seg_o  <= 7'b1000000;
        end else if (rcnt_q == REFRESH_CYCLES - 17'd1) begin
            rcnt_q <= 17'd0;
            idx_q  <= idx_next;
            an_o   <= ~(4'b0001 << idx_next);
            seg_o  <= hex_to_seg(next_digit);
        end else begin
            rcnt_q <= rcnt_q + 17'd1;
        end
    end

endmodule

// File: tb/tb_mmio_io_responder.sv
// Directed self-checking bench for mmio_io_responder with short debounce/refresh periods.
module tb_mmio_io_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] address = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic [3:0]  write_enable = 4'h0;
    logic        read_enable = 1'b0;
    logic [31:0] read_data;
    logic        read_valid;
    logic [3:0]  sw = 4'h0;
    logic [3:0]  led;
    logic [6:0]  seg;
    logic [3:0]  an;

    int n_cmp = 0;
    int n_err = 0;

    mmio_io_responder #(
        .BASE_ADDR      (32'h0000_4000),
        .DEBOUNCE_CYCLES(20'd4),
        .REFRESH_CYCLES (17'd4)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .address_i     (address),
        .write_data_i  (write_data),
        .write_enable_i(write_enable),
        .read_enable_i (read_enable),
        .read_data_o   (read_data),
        .read_valid_o  (read_valid),
        .sw_i          (sw),
        .led_o         (led),
        .seg_o         (seg),
        .an_o          (an)
    );

    always #5 clk = ~clk;

    // Applies one bus cycle at a falling edge and returns at the next falling edge.
    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we,
                         input logic re);
        address      = a;
        write_data   = d;
        write_enable = we;
        read_enable  = re;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n_cmp++; if (an !== 4'b1110) begin n_err++; $display("FAIL rst_an got %b exp 1110", an); end
        n_cmp++; if (seg !== 7'b1000000) begin n_err++; $display("FAIL rst_seg got %b exp 1000000", seg); end
        n_cmp++; if (read_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", read_valid); end
        drive(32'h4000, 32'h3, 4'b0001, 1'b0);
        drive(32'h4000, 32'h0, 4'b0000, 1'b1);
        n_cmp++; if (read_data !== 32'h3) begin n_err++; $display("FAIL pre_rst_rd got %h exp 00000003", read_data); end
        repeat (4) drive(32'h0, 32'h0, 4'b0000, 1'b0);
        n_cmp++; if (an !== 4'b1101) begin n_err++; $display("FAIL pre_rst_an got %b exp 1101", an); end
        // Reset lands mid-cycle with a read pending.
        drive(32'h4000, 32'h0, 4'b0000, 1'b1);
        read_enable = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (read_data !== 32'h0) begin n_err++; $display("FAIL mid_rst_rd got %h exp 0", read_data); end
        n_cmp++; if (read_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got %b exp 0", read_valid); end
        n_cmp++; if (led !== 4'h0) begin n_err++; $display("FAIL mid_rst_led got %h exp 0", led); end
        n_cmp++; if (an !== 4'b1110) begin n_err++; $display("FAIL mid_rst_an got %b exp 1110", an); end
        n_cmp++; if (seg !== 7'b1000000) begin n_err++; $display("FAIL mid_rst_seg got %b exp 1000000", seg); end
        @(negedge clk);
        read_enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h400C, 32'h0, 4'b0000, 1'b1);
        n_cmp++; if (read_data !== 32'h0) begin n_err++; $display("FAIL rst_timer got %h exp 0", read_data); end
        drive(32'h4008, 32'h0, 4'b0000, 1'b1);
        n_cmp++; if (read_data !== 32'h0 || read_valid !== 1'b1) begin
            n_err++; $display("FAIL rst_sw_read got %h/%b exp 0/1", read_data, read_valid); end
        drive(32'h0, 32'h0, 4'b0000, 1'b0);
        n_cmp++; if (read_valid !== 1'b0) begin n_err++; $display("FAIL valid_pulse got %b exp 0", read_valid); end
    endtask

    task automatic test_led();
        drive(32'h4000, 32'hFFFF_FFFA, 4'b0001, 1'b0);
        n_cmp++; if (led !== 4'hA) begin n_err++; $display("FAIL led_wr got %h exp a", led); end
        drive(32'h4000, 32'h0, 4'b0000, 1'b1);
        n_cmp++; if (read_data !== 32'h0000_000A) begin n_err++; $display("FAIL led_rd got %h exp 0000000a", read_data); end
        drive(32'h4000, 32'hFFFF_FFFA, 4'b1110, 1'b0);
        n_cmp++; if (led !== 4'hA) begin n_err++; $display("FAIL led_lanes got %h exp a", led); end
        drive(32'h4000, 32'h5, 4'b0001, 1'b1);
        n_cmp++; if (read_data !== 32'hA || led !== 4'h5) begin
            n_err++; $display("FAIL led_rw got rd %h led %h exp rd 0000000a led 5", read_data, led); end
        drive(32'h4000, 32'hA, 4'b0001, 1'b0);
    endtask

    task automatic test_display();
        logic [6:0] exp_seg [4];
        logic [3:0] prev_an;
        logic       found;
        exp_seg[0] = 7'b0001110;
        exp_seg[1] = 7'b0000110;
        exp_seg[2] = 7'b0100100;
        exp_seg[3] = 7'b1111001;
        drive(32'h4004, 32'h0000_12EF, 4'b0011, 1'b0);
        drive(32'h4004, 32'h0, 4'b0000, 1'b1);
        n_cmp++; if (read_data !== 32'h0000_12EF) begin n_err++; $display("FAIL seg_rd got %h exp 000012ef", read_data); end
        read_enable = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            prev_an = an;
            @(negedge clk);
            if (prev_an == 4'b0111 && an == 4'b1110) found = 1'b1;
        end
        n_cmp++; if (!found) begin n_err++; $display("FAIL scan_start got no digit-0 refresh exp one within 40 cycles"); end
        for (int j = 0; j < 16 && found; j++) begin
            n_cmp++; if (an !== ~(4'b0001 << (j / 4)) || seg !== exp_seg[j / 4]) begin
                n_err++; $display("FAIL scan_%0d got an %b seg %b exp an %b seg %b", j, an, seg,
                                  ~(4'b0001 << (j / 4)), exp_seg[j / 4]); end
            @(negedge clk);
        end
    endtask

    task automatic test_switches();
        logic [31:0] exp_rd;
        sw = 4'b0101;
        for (int e = 0; e < 9; e++) begin
            drive(32'h4008, 32'h0, 4'b0000, 1'b1);
            exp_rd = (e >= 6) ? 32'h5 : 32'h0;
            n_cmp++; if (read_data !== exp_rd) begin
                n_err++; $display("FAIL sw_edge_%0d got %h exp %h", e, read_data, exp_rd); end
        end
        drive(32'h4008, 32'hF, 4'b1111, 1'b0);
        sw = 4'b1101;
        repeat (3) drive(32'h0, 32'h0, 4'b0000, 1'b0);
        sw = 4'b0101;
        for (int e = 0; e < 10; e++) begin
            drive(32'h4008, 32'h0, 4'b0000, 1'b1);
            n_cmp++; if (read_data !== 32'h5) begin
                n_err++; $display("FAIL sw_glitch_%0d got %h exp 00000005", e, read_data); end
        end
    endtask

    task automatic test_timer();
        drive(32'h400C, 32'h0000_0100, 4'b1111, 1'b0);
        drive(32'h400C, 32'h1234_5678, 4'b1111, 1'b1);
        n_cmp++; if (read_data !== 32'h0000_0100) begin n_err++; $display("FAIL tmr_rw got %h exp 00000100", read_data); end
        drive(32'h400C, 32'h0, 4'b0000, 1'b1);
        n_cmp++; if (read_data !== 32'h1234_5678) begin n_err++; $display("FAIL tmr_rd0 got %h exp 12345678", read_data); end
        drive(32'h400C, 32'h0, 4'b0000, 1'b1);
        n_cmp++; if (read_data !== 32'h1234_5679) begin n_err++; $display("FAIL tmr_rd1 got %h exp 12345679", read_data); end
        drive(32'h400C, 32'hFFFF_FFFF, 4'b1111, 1'b0);
        drive(32'h400C, 32'h0, 4'b0000, 1'b1);
        n_cmp++; if (read_data !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL tmr_max got %h exp ffffffff", read_data); end
        drive(32'h400C, 32'h0, 4'b0000, 1'b1);
        n_cmp++; if (read_data !== 32'h0) begin n_err++; $display("FAIL tmr_wrap got %h exp 00000000", read_data); end
        drive(32'h400C, 32'h0, 4'b1111, 1'b0);
        drive(32'h400C, 32'hAB00_00CD, 4'b1000, 1'b0);
        drive(32'h400C, 32'h0, 4'b0000, 1'b1);
        n_cmp++; if (read_data !== 32'hAB00_0000) begin n_err++; $display("FAIL tmr_part got %h exp ab000000", read_data); end
        drive(32'h400C, 32'h0, 4'b0000, 1'b1);
        n_cmp++; if (read_data !== 32'hAB00_0001) begin n_err++; $display("FAIL tmr_part_inc got %h exp ab000001", read_data); end
    endtask

    task automatic test_miss();
        drive(32'h4010, 32'hFFFF_FFFF, 4'b1111, 1'b1);
        n_cmp++; if (read_data !== 32'h0 || read_valid !== 1'b1) begin
            n_err++; $display("FAIL miss_hi got %h/%b exp 0/1", read_data, read_valid); end
        drive(32'h3FFC, 32'hFFFF_FFFF, 4'b1111, 1'b1);
        n_cmp++; if (read_data !== 32'h0 || read_valid !== 1'b1) begin
            n_err++; $display("FAIL miss_lo got %h/%b exp 0/1", read_data, read_valid); end
        n_cmp++; if (led !== 4'hA) begin n_err++; $display("FAIL miss_led got %h exp a", led); end
        drive(32'h4004, 32'h0, 4'b0000, 1'b1);
        n_cmp++; if (read_data !== 32'h0000_12EF) begin n_err++; $display("FAIL miss_seg got %h exp 000012ef", read_data); end
        drive(32'h0, 32'h0, 4'b0000, 1'b0);
        n_cmp++; if (read_valid !== 1'b0 || read_data !== 32'h0000_12EF) begin
            n_err++; $display("FAIL rd_hold got %h/%b exp 000012ef/0", read_data, read_valid); end
    endtask

    initial begin
        test_reset();
        test_led();
        test_display();
        test_switches();
        test_timer();
        test_miss();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
